// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional macro ALU_ARB_ILLEGAL_OP_EN flags opcodes above 4'b1001 via res_err and zeroes res_data.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,

  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,

  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_id,
  output logic [DATA_WIDTH-1:0]    res_data,
  output logic                     res_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]               state_q, state_d;
  logic                     lastGrant_q;
  logic [DATA_WIDTH-1:0]    srcA_q, srcB_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic                     id_q;

  logic                     resValid_q;
  logic                     resId_q;
  logic [DATA_WIDTH-1:0]    resData_q;

  logic                     grantValid;
  logic                     grantId;
  logic                     accept;
  logic                     resTaken;

  // On contention the requester that did not win last time is preferred.
  always_comb begin
    grantValid = 1'b0;
    grantId    = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grantValid = 1'b1;
        grantId    = ~lastGrant_q;
      end else if (req0_valid) begin
        grantValid = 1'b1;
        grantId    = 1'b0;
      end else if (req1_valid) begin
        grantValid = 1'b1;
        grantId    = 1'b1;
      end
    end
  end

  assign req0_ready = grantValid & ~grantId;
  assign req1_ready = grantValid &  grantId;
  assign accept     = grantValid;
  assign resTaken   = (state_q == RESP) & res_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srcA_q      <= '0;
      srcB_q      <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      lastGrant_q <= 1'b1;
    end else if (accept) begin
      srcA_q      <= grantId ? req1_srca : req0_srca;
      srcB_q      <= grantId ? req1_srcb : req0_srcb;
      op_q        <= grantId ? req1_op   : req0_op;
      id_q        <= grantId;
      lastGrant_q <= grantId;
    end
  end

  // Latched operands feed the ALU continuously; only the EXEC cycle matters.
  assign alu_srca = srcA_q;
  assign alu_srcb = srcB_q;
  assign alu_op   = op_q;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  localparam logic [OPCODE_LENGTH-1:0] LAST_LEGAL_OP = OPCODE_LENGTH'(9);

  logic opIllegal;
  logic resErr_q;

  assign opIllegal = (op_q > LAST_LEGAL_OP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resValid_q <= 1'b0;
      resId_q    <= 1'b0;
      resData_q  <= '0;
      resErr_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      resValid_q <= 1'b1;
      resId_q    <= id_q;
      resData_q  <= opIllegal ? '0 : alu_result;
      resErr_q   <= opIllegal;
    end else if (resTaken) begin
      resValid_q <= 1'b0;
    end
  end

  assign res_err = resErr_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resValid_q <= 1'b0;
      resId_q    <= 1'b0;
      resData_q  <= '0;
    end else if (state_q == EXEC) begin
      resValid_q <= 1'b1;
      resId_q    <= id_q;
      resData_q  <= alu_result;
    end else if (resTaken) begin
      resValid_q <= 1'b0;
    end
  end

  assign res_err = 1'b0;
`endif

  assign res_valid = resValid_q;
  assign res_id    = resId_q;
  assign res_data  = resData_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter with a behavioural ALU and arbitration model.
// Honours ALU_ARB_ILLEGAL_OP_EN when computing expected res_err/res_data.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int OL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [OL-1:0] req0_op, req1_op;
  logic [DW-1:0] alu_srca, alu_srcb, alu_result;
  logic [OL-1:0] alu_op;
  logic          res_valid, res_ready, res_id, res_err;
  logic [DW-1:0] res_data;

  int  vectors = 0;
  int  miscompares = 0;
  bit  lastGrantModel = 1'b1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_srca(req0_srca),
    .req0_srcb(req0_srcb), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_srca(req1_srca),
    .req1_srcb(req1_srcb), .req1_op(req1_op),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .res_err(res_err)
  );

  // Stand-in for the shared ALU; undefined opcodes produce zero.
  function automatic logic [DW-1:0] aluRef(input logic [OL-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << b[4:0];
      4'd5:    return a >> b[4:0];
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return DW'($signed(a) >>> b[4:0]);
      4'd9:    return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign alu_result = aluRef(alu_op, alu_srca, alu_srcb);

  function automatic logic [DW-1:0] expData(input logic [OL-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    if (op > 4'd9) return '0;
`endif
    return aluRef(op, a, b);
  endfunction

  function automatic logic expErr(input logic [OL-1:0] op);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    return (op > 4'd9);
`else
    return (op != op);
`endif
  endfunction

  // Returns {granted, id}; two contenders go to whoever was not served last.
  function automatic logic [1:0] pickGrant(input logic v0, input logic v1, input bit last);
    if (v0 && v1) return {1'b1, ~last};
    if (v0)       return 2'b10;
    if (v1)       return 2'b11;
    return 2'b00;
  endfunction

  // Drives one arbitration round from the currently applied inputs and returns what was observed.
  task automatic runTxn(input logic preReady, output logic r0, output logic r1,
                        output logic [DW-1:0] aA, output logic [DW-1:0] aB, output logic [OL-1:0] aOp,
                        output int lat, output logic [DW-1:0] data, output logic id,
                        output logic err, output bit timedOut);
    res_ready = preReady;
    timedOut = 1'b0;
    lat = 0;
    data = '0; id = 1'b0; err = 1'b0;
    #1;
    r0 = req0_ready;
    r1 = req1_ready;
    @(posedge clk); #1;
    if (r0) req0_valid = 1'b0;
    if (r1) req1_valid = 1'b0;
    aA = alu_srca; aB = alu_srcb; aOp = alu_op;
    if (!(r0 || r1)) begin
      res_ready = 1'b0;
      return;
    end
    lat = 1;
    while (!res_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) begin
      timedOut = 1'b1;
      res_ready = 1'b0;
      return;
    end
    data = res_data; id = res_id; err = res_err;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready got %b%b want 00", req0_ready, req1_ready); end
    vectors++; if (alu_srca !== '0 || alu_srcb !== '0 || alu_op !== '0) begin miscompares++; $display("[TB] FAIL reset_alu got %h %h %h want 0", alu_srca, alu_srcb, alu_op); end
    vectors++; if (res_valid !== 1'b0 || res_id !== 1'b0 || res_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_res got v%b id%b err%b want 000", res_valid, res_id, res_err); end
    vectors++; if (res_data !== '0) begin miscompares++; $display("[TB] FAIL reset_data got %h want 0", res_data); end
    reset = 1'b0;
    lastGrantModel = 1'b1;
    @(posedge clk); #1;
    vectors++; if (res_valid !== 1'b0 || req0_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_after_reset got v%b r0%b want 00", res_valid, req0_ready); end
  endtask

  task automatic test_single();
    logic r0, r1, id, err; logic [DW-1:0] aA, aB, data; logic [OL-1:0] aOp; int lat; bit to;
    req0_valid = 1'b1; req0_srca = 32'd5; req0_srcb = 32'd7; req0_op = 4'b0010;
    runTxn(1'b0, r0, r1, aA, aB, aOp, lat, data, id, err, to);
    lastGrantModel = 1'b0;
    vectors++; if (r0 !== 1'b1 || r1 !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ready got %b%b want 10", r0, r1); end
    vectors++; if (aA !== 32'd5 || aB !== 32'd7 || aOp !== 4'b0010) begin miscompares++; $display("[TB] FAIL single_alu got %0d %0d %b want 5 7 0010", aA, aB, aOp); end
    vectors++; if (to || lat != 2) begin miscompares++; $display("[TB] FAIL single_latency got %0d (timeout %0d) want 2", lat, to); end
    vectors++; if (id !== 1'b0 || data !== 32'd12 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL single_result got id%b %0d err%b want id0 12 err0", id, data, err); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_release got %b want 0", res_valid); end
  endtask

  task automatic test_contention();
    logic r0, r1, id, err; logic [DW-1:0] aA, aB, data; logic [OL-1:0] aOp; int lat; bit to;
    // Reset first so requester 0 wins by the documented reset priority.
    reset = 1'b1; #2; reset = 1'b0; lastGrantModel = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_srca = 32'd10; req0_srcb = 32'd3; req0_op = 4'b0110;
    req1_valid = 1'b1; req1_srca = 32'd20; req1_srcb = 32'd4; req1_op = 4'b0110;
    runTxn(1'b0, r0, r1, aA, aB, aOp, lat, data, id, err, to);
    vectors++; if (r0 !== 1'b1 || r1 !== 1'b0 || to || id !== 1'b0 || data !== 32'd7) begin miscompares++; $display("[TB] FAIL contention_first got r%b%b id%b %0d want r10 id0 7", r0, r1, id, data); end
    runTxn(1'b0, r0, r1, aA, aB, aOp, lat, data, id, err, to);
    lastGrantModel = 1'b1;
    vectors++; if (r1 !== 1'b1 || r0 !== 1'b0 || to || id !== 1'b1 || data !== 32'd16) begin miscompares++; $display("[TB] FAIL contention_second got r%b%b id%b %0d want r01 id1 16", r0, r1, id, data); end
  endtask

  task automatic test_alternate();
    logic r0, r1, id, err; logic [DW-1:0] aA, aB, data, e; logic [OL-1:0] aOp; int lat; bit to;
    logic [1:0] g;
    logic [DW-1:0] a [2]; logic [DW-1:0] b [2]; logic [OL-1:0] op [2];
    for (int i = 0; i < 6; i++) begin
      if (!req0_valid) begin a[0] = $urandom; b[0] = $urandom; op[0] = 4'($urandom_range(0, 9));
        req0_srca = a[0]; req0_srcb = b[0]; req0_op = op[0]; req0_valid = 1'b1; end
      if (!req1_valid) begin a[1] = $urandom; b[1] = $urandom; op[1] = 4'($urandom_range(0, 9));
        req1_srca = a[1]; req1_srcb = b[1]; req1_op = op[1]; req1_valid = 1'b1; end
      g = pickGrant(1'b1, 1'b1, lastGrantModel);
      e = expData(op[g[0]], a[g[0]], b[g[0]]);
      runTxn(1'b0, r0, r1, aA, aB, aOp, lat, data, id, err, to);
      lastGrantModel = g[0];
      vectors++; if (to || id !== g[0] || id !== 1'(i % 2) || {r1, r0} !== (g[0] ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL alternate_grant[%0d] got id%b r%b%b want id%b", i, id, r1, r0, g[0]); end
      vectors++; if (data !== e) begin miscompares++; $display("[TB] FAIL alternate_data[%0d] got %h want %h", i, data, e); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d, e; logic id, r0;
    req0_valid = 1'b1; req0_srca = 32'h1234; req0_srcb = 32'h0F0F; req0_op = 4'b0001;
    req1_valid = 1'b1; req1_srca = 32'd9;    req1_srcb = 32'd4;    req1_op = 4'b0010;
    res_ready = 1'b0;
    e = expData(4'b0001, 32'h1234, 32'h0F0F);
    #1; r0 = req0_ready;
    @(posedge clk); #1; req0_valid = 1'b0;
    lastGrantModel = 1'b0;
    vectors++; if (r0 !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_grant got %b want 1", r0); end
    @(posedge clk); #1;
    d = res_data; id = res_id;
    vectors++; if (res_valid !== 1'b1 || d !== e || id !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_result got v%b %h id%b want v1 %h id0", res_valid, d, id, e); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++; if (res_valid !== 1'b1 || res_data !== d || res_id !== id || req0_ready !== 1'b0 || req1_ready !== 1'b0)
        begin miscompares++; $display("[TB] FAIL bp_hold[%0d] got v%b %h id%b r%b%b want v1 %h id%b r00", i, res_valid, res_data, res_id, req0_ready, req1_ready, d, id); end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    vectors++; if (res_valid !== 1'b0 || req1_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release got v%b r1%b want v0 r1 1", res_valid, req1_ready); end
    @(posedge clk); #1; req1_valid = 1'b0;
    lastGrantModel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== 32'd13) begin miscompares++; $display("[TB] FAIL bp_queued got v%b id%b %0d want v1 id1 13", res_valid, res_id, res_data); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    logic r0, r1, id, err; logic [DW-1:0] aA, aB, data; logic [OL-1:0] aOp; int lat; bit to;
    req0_valid = 1'b1; req0_srca = 32'hDEAD; req0_srcb = 32'h1; req0_op = 4'b0010;
    @(posedge clk); #1; req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++; if (res_valid !== 1'b0 || alu_srca !== '0 || alu_op !== '0 || res_data !== '0) begin miscompares++; $display("[TB] FAIL reset_exec got v%b %h %h %h want all 0", res_valid, alu_srca, alu_op, res_data); end
    @(negedge clk); reset = 1'b0;
    lastGrantModel = 1'b1;
    @(posedge clk); #1;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_exec_discard got %b want 0", res_valid); end
    req1_valid = 1'b1; req1_srca = 32'hF0; req1_srcb = 32'hFF; req1_op = 4'b0011;
    runTxn(1'b0, r0, r1, aA, aB, aOp, lat, data, id, err, to);
    lastGrantModel = 1'b1;
    vectors++; if (r1 !== 1'b1 || to || lat != 2 || id !== 1'b1 || data !== 32'h0F) begin miscompares++; $display("[TB] FAIL reset_then_xor got r1%b lat%0d id%b %h want r1 1 lat2 id1 0f", r1, lat, id, data); end
  endtask

  task automatic test_illegal_op();
    logic r0, r1, id, err; logic [DW-1:0] aA, aB, data; logic [OL-1:0] aOp; int lat; bit to;
    logic [OL-1:0] ops [3];
    ops[0] = 4'b1111; ops[1] = 4'b1010; ops[2] = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_srca = 32'hA5A5_0F0F; req0_srcb = 32'h0000_00F3; req0_op = ops[i];
      runTxn(1'b0, r0, r1, aA, aB, aOp, lat, data, id, err, to);
      lastGrantModel = 1'b0;
      vectors++; if (to || err !== expErr(ops[i]) || data !== expData(ops[i], 32'hA5A5_0F0F, 32'h0000_00F3))
        begin miscompares++; $display("[TB] FAIL illegal_op[%b] got err%b %h want err%b %h", ops[i], err, data, expErr(ops[i]), expData(ops[i], 32'hA5A5_0F0F, 32'h0000_00F3)); end
    end
  endtask

  task automatic test_random();
    logic r0, r1, id, err; logic [DW-1:0] aA, aB, data, e; logic [OL-1:0] aOp; int lat; bit to;
    logic [1:0] g; logic v0, v1, pr;
    logic [DW-1:0] a [2]; logic [DW-1:0] b [2]; logic [OL-1:0] op [2];
    for (int i = 0; i < 40; i++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin a[0] = $urandom; b[0] = $urandom; op[0] = 4'($urandom);
        req0_srca = a[0]; req0_srcb = b[0]; req0_op = op[0]; req0_valid = 1'b1; end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin a[1] = $urandom; b[1] = $urandom; op[1] = 4'($urandom);
        req1_srca = a[1]; req1_srcb = b[1]; req1_op = op[1]; req1_valid = 1'b1; end
      v0 = req0_valid; v1 = req1_valid;
      pr = 1'($urandom_range(0, 1));
      g = pickGrant(v0, v1, lastGrantModel);
      e = g[1] ? expData(op[g[0]], a[g[0]], b[g[0]]) : '0;
      runTxn(pr, r0, r1, aA, aB, aOp, lat, data, id, err, to);
      vectors++; if ({r1, r0} !== (!g[1] ? 2'b00 : (g[0] ? 2'b10 : 2'b01))) begin miscompares++; $display("[TB] FAIL rand_ready[%0d] got %b%b want grant %b", i, r1, r0, g); end
      if (g[1]) begin
        lastGrantModel = g[0];
        vectors++; if (to || lat != 2 || id !== g[0] || data !== e || err !== expErr(op[g[0]]))
          begin miscompares++; $display("[TB] FAIL rand_result[%0d] got lat%0d id%b %h err%b want lat2 id%b %h err%b", i, lat, id, data, err, g[0], e, expErr(op[g[0]])); end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req0_srca = '0; req0_srcb = '0; req0_op = '0;
    req1_valid = 1'b0; req1_srca = '0; req1_srcb = '0; req1_op = '0;
    test_reset();
    test_single();
    test_contention();
    test_alternate();
    test_backpressure();
    test_reset_mid_exec();
    test_illegal_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
